// File: rtl/free_list.sv
// Physical-register free list for rename: a circular FIFO of free IDs with
// a speculative head, a committed head for flush recovery, and a tail for frees.
module free_list #(
  parameter int DEPTH    = 32,
  parameter int NUM_ARCH = 34,
  parameter int NUM_PHYS = 64
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        SYS,
  input  logic                        Shift_IN,
  input  logic                        STALL_IN,
  input  logic                        Commit_IN,
  input  logic                        Free_Valid_IN,
  input  logic [$clog2(NUM_PHYS)-1:0] Free_ID_IN,
  output logic [$clog2(NUM_PHYS)-1:0] RegID_OUT,
  output logic                        Empty_OUT,
  output logic                        STALL_OUT,
  output logic [$clog2(DEPTH):0]      Count_OUT,
  output logic                        Error_OUT
);

  localparam int IDX_W     = $clog2(DEPTH);
  localparam int PTR_W     = IDX_W + 1;
  localparam int ID_W      = $clog2(NUM_PHYS);
  localparam int INIT_FREE = NUM_PHYS - NUM_ARCH;

  logic [ID_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] commit_head_r;
  logic             error_r;

  logic             full_s;
  logic             alloc_s;
  logic             free_s;
  logic             commit_ok_s;
  logic             error_set_s;
  logic [PTR_W-1:0] commit_head_nxt_s;
  logic [PTR_W-1:0] head_nxt_s;
  logic [PTR_W-1:0] tail_nxt_s;

  // Occupancy is the wrap-corrected pointer distance; the extra wrap bit
  // lets a distance of DEPTH be told apart from zero.
  assign Count_OUT = tail_r - head_r;
  assign Empty_OUT = (Count_OUT == {PTR_W{1'b0}});
  assign STALL_OUT = Empty_OUT;
  assign full_s    = (Count_OUT == PTR_W'(DEPTH));
  assign RegID_OUT = mem_r[head_r[IDX_W-1:0]];
  assign Error_OUT = error_r;

  // Next-state decode for allocate, free, commit and flush recovery.
  always_comb begin
    alloc_s           = Shift_IN & ~STALL_IN & ~SYS & ~Empty_OUT;
    free_s            = Free_Valid_IN & ~full_s;
    commit_ok_s       = Commit_IN & (commit_head_r != head_r);
    error_set_s       = (Free_Valid_IN & full_s) | (Commit_IN & ~commit_ok_s);
    commit_head_nxt_s = commit_head_r;
    head_nxt_s        = head_r;
    tail_nxt_s        = tail_r;
    if (commit_ok_s) begin
      commit_head_nxt_s = commit_head_r + PTR_W'(1);
    end else begin
      commit_head_nxt_s = commit_head_r;
    end
    // Flush rewinds to the committed point, which returns squashed IDs to the pool.
    if (SYS) begin
      head_nxt_s = commit_head_nxt_s;
    end else if (alloc_s) begin
      head_nxt_s = head_r + PTR_W'(1);
    end else begin
      head_nxt_s = head_r;
    end
    if (free_s) begin
      tail_nxt_s = tail_r + PTR_W'(1);
    end else begin
      tail_nxt_s = tail_r;
    end
  end

  // Pointer and sticky error registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      head_r        <= {PTR_W{1'b0}};
      commit_head_r <= {PTR_W{1'b0}};
      tail_r        <= PTR_W'(INIT_FREE);
      error_r       <= 1'b0;
    end else begin
      head_r        <= head_nxt_s;
      commit_head_r <= commit_head_nxt_s;
      tail_r        <= tail_nxt_s;
      error_r       <= error_r | error_set_s;
    end
  end

  // ID storage; reset preloads every physical ID not holding an architectural mapping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i < INIT_FREE) begin
          mem_r[i] <= ID_W'(NUM_ARCH + i);
        end else begin
          mem_r[i] <= {ID_W{1'b0}};
        end
      end
    end else begin
      if (free_s) begin
        mem_r[tail_r[IDX_W-1:0]] <= Free_ID_IN;
      end else begin
        mem_r[tail_r[IDX_W-1:0]] <= mem_r[tail_r[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001: Parameter DEPTH, default 32, number of free-list slots (power of two).
REQ-002: Parameter NUM_ARCH, default 34, architectural registers; physical IDs 0..NUM_ARCH-1 are mapped at reset.
REQ-003: Parameter NUM_PHYS, default 64, physical registers; IDs are 6 bits.
REQ-004: CLK  input  1  sole clock; all state changes on rising edge.
REQ-005: RESET_N  input  1  asynchronous, active-low reset.
REQ-006: SYS  input  1  flush/recovery request, sampled at CLK rise.
REQ-007: Shift_IN  input  1  allocate request from the rename table; consume head ID.
REQ-008: STALL_IN  input  1  rename stall; blocks allocation when high.
REQ-009: Commit_IN  input  1  retire of one renamed instruction; advances committed head.
REQ-010: Free_Valid_IN  input  1  retire frees the previous mapping in Free_ID_IN.
REQ-011: Free_ID_IN  input  6  physical ID being returned.
REQ-012: RegID_OUT  output  6  ID at head slot, combinational from storage.
REQ-013: Empty_OUT  output  1  high when Count_OUT == 0.
REQ-014: STALL_OUT  output  1  equals Empty_OUT; stalls renaming.
REQ-015: Count_OUT  output  6  number of free IDs held (0..DEPTH).
REQ-016: Error_OUT  output  1  sticky; overflow or commit underflow seen since reset.

Function
REQ-017: Storage is a DEPTH-entry circular buffer with pointers head, tail, commit_head, each log2(DEPTH)+1 bits (wrap bit) to distinguish full from empty.
REQ-018: Allocate = Shift_IN & !STALL_IN & !SYS & (Count_OUT != 0); on allocate, head increments by 1 modulo 2*DEPTH.
REQ-019: Shift_IN is treated as a level per cycle; high on N consecutive edges consumes N IDs.
REQ-020: Allocate when empty is ignored with no state change; no bypass of a same-cycle freed ID to RegID_OUT.
REQ-021: Free = Free_Valid_IN & (Count_OUT != DEPTH); on free, Free_ID_IN is written at tail and tail increments.
REQ-022: Free_Valid_IN when full is dropped and sets Error_OUT.
REQ-023: Commit_IN advances commit_head by 1 if commit_head != head; otherwise it is ignored and sets Error_OUT.
REQ-024: Allocate, free and commit in the same cycle are all performed; Count_OUT next = Count_OUT - alloc + free.
REQ-025: On SYS at a rising edge, head <= commit_head after that cycle's commit update, tail/free processed normally, allocation suppressed; IDs allocated to squashed instructions become free again.
REQ-026: Count_OUT is always tail - head (6-bit, wrap-corrected) computed from registered pointers.
REQ-027: Wrap-around: pointer index bits roll from DEPTH-1 to 0 and toggle the wrap bit; full when indices match and wrap bits differ.
REQ-028: Latency: a freed ID is visible on RegID_OUT no earlier than the cycle after it is written.

Reset
REQ-029: RESET_N low asynchronously loads slot i with NUM_ARCH+i for i = 0..NUM_PHYS-NUM_ARCH-1; other slots are 0.
REQ-030: Reset values: head=0, commit_head=0, tail=NUM_PHYS-NUM_ARCH (30), Count_OUT=30, RegID_OUT=34, Empty_OUT=0, STALL_OUT=0, Error_OUT=0.
REQ-031: Reset asserted mid-operation discards all in-flight allocations and frees; state re-initialises as REQ-029/030.

Verification
REQ-032: Reset, then Shift_IN high 3 cycles -> RegID_OUT 34,35,36 then 37; Count_OUT 27.
REQ-033: Drain 30 allocations -> Empty_OUT=STALL_OUT=1, Count_OUT=0; further Shift_IN leaves state unchanged, Error_OUT stays 0.
REQ-034: When empty, Free_Valid_IN with ID 5 and Shift_IN same cycle -> no allocation; next cycle RegID_OUT=5, Count_OUT=1.
REQ-035: Allocate 4 (34..37), Commit_IN once, then SYS -> head returns to slot 1; RegID_OUT=35, Count_OUT=29.
REQ-036: With free list full (32 entries), Free_Valid_IN -> entry dropped, Count_OUT stays 32, Error_OUT=1; Commit_IN with nothing outstanding also sets Error_OUT.
REQ-037: Cycle 40 allocate/free pairs -> pointers wrap past slot 31 with no loss; Count_OUT constant and IDs returned in FIFO order.
